adc_menu_controller: RTL and testbench
======================================

// Module: adc_menu_controller
// PURPOSE
//  FSM-based menu controller that configures the ADC display datapath from three push-buttons.
//  Drives the display-mux source select, output-format select and SAR/ramp algorithm select.
//  Replaces the slide-switch selection currently used at top level.
//  Sits between the raw board buttons and the ADC/XADC/switch subsystems and the display mux.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000    consecutive stable synchronized cycles required to accept a button level (10 ms @100 MHz)
//  TIMEOUT_CYCLES   500_000_000  menu inactivity limit before abandoning edits (5 s)
//  SCAN_PERIOD      300_000_000  auto-scan dwell per source (AUTO_SCAN_EN only)
// PORTS
//  clk               in   1   system clock; the only clock
//  reset             in   1   synchronous, active-low reset
//  btn_mode          in   1   raw asynchronous button: enter menu / next field
//  btn_up            in   1   raw asynchronous button: increment pending value
//  btn_enter         in   1   raw asynchronous button: commit and exit
//  adc_select        out  2   00 switches, 01 XADC, 10 PWM ADC, 11 R2R ADC
//  bin_bcd_select    out  2   output-format code to the ADC subsystems
//  algorithm_select  out  1   0 ramp, 1 SAR
//  menu_active       out  1   1 while in any menu state
//  menu_display      out  16  4 hex nibbles shown instead of ADC data while menu_active=1
// BEHAVIOUR
//  Reset: sampled with reset==0 at a clk edge. Effects:
//   - state=DISPLAY, adc_select=01, bin_bcd_select=01, algorithm_select=0
//   - menu_active=0, menu_display=16'h0000
//   - all counters and pending registers cleared
//   - reset mid-menu discards pending edits
//  Buttons:
//   - Each button passes through a 2-FF synchronizer, then a debounce counter.
//   - The debounced level changes only after DEBOUNCE_CYCLES identical synchronized samples.
//   - A 0->1 transition of the debounced level yields a 1-cycle press pulse.
//   - Pulse latency: DEBOUNCE_CYCLES+3 cycles after the raw edge settles.
//   - Release generates no pulse.
//  FSM states: DISPLAY, SEL_SRC, SEL_FMT, SEL_ALG.
//   - DISPLAY --mode--> SEL_SRC; pending {src,fmt,alg} loaded from the committed outputs.
//   - SEL_SRC --mode--> SEL_FMT --mode--> SEL_ALG --mode--> SEL_SRC (wraps).
//   - up in SEL_SRC/SEL_FMT: pending value +1 mod 4 (11 wraps to 00). up in SEL_ALG: toggle.
//   - enter in a menu state: the cycle after the pulse, the outputs take the pending values and state=DISPLAY.
//   - enter in DISPLAY: ignored.
//   - Timeout: TIMEOUT_CYCLES cycles with no press pulse while in a menu state -> DISPLAY.
//     Pending values are discarded and the outputs are unchanged.
//     The timeout counter clears on every pulse and on menu entry.
//  Simultaneous pulses in one cycle: priority enter > mode > up; lower-priority pulses are dropped.
//  Outputs are registered and change only on commit (or auto-scan). No glitches, no partial updates.
//  menu_active=1 in SEL_* states.
//  menu_display layout:
//   - [15:12] = field id (1 SRC, 2 FMT, 3 ALG)
//   - [11:4]  = 0
//   - [3:0]   = pending value
//   - In DISPLAY, menu_display=16'h0000.
// CONFIGURATION
//  Macro AUTO_SCAN_EN.
//  When defined:
//   - up pulse in DISPLAY toggles an internal scan flag (cleared by reset).
//   - While the flag is set and state=DISPLAY, adc_select advances +1 mod 4 every SCAN_PERIOD cycles.
//   - The scan counter clears on menu entry.
//   - Committing from the menu clears the flag.
//  When not defined: up in DISPLAY is ignored, and adc_select changes only on commit.
// STRUCTURE
//  Package adc_menu_pkg contains:
//   - typedef enum logic [1:0] menu_state_t {MS_DISPLAY, MS_SEL_SRC, MS_SEL_FMT, MS_SEL_ALG}
//   - localparams SRC_SWITCHES=2'b00, SRC_XADC=2'b01, SRC_PWM=2'b10, SRC_R2R=2'b11
//   - localparams FIELD_SRC=4'h1, FIELD_FMT=4'h2, FIELD_ALG=4'h3
//  Sub-module button_debouncer (synchronizer, debounce counter, rising-edge pulse), instantiated 3x.
//  The FSM, pending registers, timeout counter and scan counter live in this module.
// TESTING
//  Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, SCAN_PERIOD=20.
//  1. reset=0 for 2 cycles
//     -> adc_select=01, bin_bcd_select=01, algorithm_select=0, menu_active=0, menu_display=0000.
//  2. btn_mode toggles every 2 cycles for 10 cycles, then held high 10 cycles
//     -> exactly one pulse; state SEL_SRC, menu_display=16'h1001.
//  3. mode, up, up, enter
//     -> adc_select 01->11 exactly one cycle after the enter pulse; menu_active=0.
//  4. mode, up x3, mode, up, mode, up, mode, enter
//     -> pending src 01->00 via wrap, menu_display=16'h1000 after the final mode.
//     -> commit gives adc_select=00, bin_bcd_select=10, algorithm_select=1.
//  5. mode, up, then no press for 50 cycles
//     -> state DISPLAY, menu_active=0, adc_select stays 01.
//  6. In SEL_SRC, enter and up pulse in the same cycle
//     -> commit with no increment.
//     Separately, reset=0 mid-menu after edits -> reset values, pending discarded.
//     With AUTO_SCAN_EN: up in DISPLAY, wait 20 cycles -> adc_select 01->10.

Source files
------------

// File: rtl/adc_menu_pkg.sv
// Shared state encoding, source codes and menu-display field ids for the ADC menu controller.
// Pure declarations: no latency, no backpressure.
package adc_menu_pkg;

    typedef enum logic [1:0] {
        MS_DISPLAY = 2'd0,
        MS_SEL_SRC = 2'd1,
        MS_SEL_FMT = 2'd2,
        MS_SEL_ALG = 2'd3
    } menu_state_t;

    localparam logic [1:0] SRC_SWITCHES = 2'b00;
    localparam logic [1:0] SRC_XADC     = 2'b01;
    localparam logic [1:0] SRC_PWM      = 2'b10;
    localparam logic [1:0] SRC_R2R      = 2'b11;

    localparam logic [3:0] FIELD_SRC = 4'h1;
    localparam logic [3:0] FIELD_FMT = 4'h2;
    localparam logic [3:0] FIELD_ALG = 4'h3;

    localparam logic [1:0] FMT_RESET = 2'b01;

    function automatic logic [15:0] menu_word(input menu_state_t st, input logic [1:0] src,
                                              input logic [1:0] fmt, input logic alg);
        logic [15:0] w;
        w = 16'h0000;
        case (st)
            MS_SEL_SRC: w = {FIELD_SRC, 8'h00, 2'b00, src};
            MS_SEL_FMT: w = {FIELD_FMT, 8'h00, 2'b00, fmt};
            MS_SEL_ALG: w = {FIELD_ALG, 8'h00, 3'b000, alg};
            default:    w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-FF synchronizer -> debounce counter -> one-cycle press pulse on debounced rise.
// Latency DEBOUNCE_CYCLES+3 cycles from a settled raw edge; no backpressure, release gives no pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          prev_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronized level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the qualification window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            prev_q   <= stable_q;
            pulse_q  <= stable_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/adc_menu_controller.sv
// Three-button menu FSM selecting ADC source, output format and algorithm; commits one cycle after enter pulse.
// No backpressure; optional source auto-scan in DISPLAY under macro AUTO_SCAN_EN.
module adc_menu_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000,
    parameter int unsigned SCAN_PERIOD     = 300_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_enter,
    output logic [1:0]  adc_select,
    output logic [1:0]  bin_bcd_select,
    output logic        algorithm_select,
    output logic        menu_active,
    output logic [15:0] menu_display
);

    import adc_menu_pkg::*;

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic mode_p;
    logic up_p;
    logic enter_p;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .btn_i(btn_mode), .pulse_o(mode_p)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .btn_i(btn_up), .pulse_o(up_p)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk(clk), .reset(reset), .btn_i(btn_enter), .pulse_o(enter_p)
    );

    menu_state_t   state_q, state_d;
    logic [1:0]    src_q, src_d;
    logic [1:0]    fmt_q, fmt_d;
    logic          alg_q, alg_d;
    logic [1:0]    p_src_q, p_src_d;
    logic [1:0]    p_fmt_q, p_fmt_d;
    logic          p_alg_q, p_alg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          active_q, active_d;
    logic [15:0]   disp_q, disp_d;
`ifdef AUTO_SCAN_EN
    localparam int unsigned SW = $clog2(SCAN_PERIOD + 1);
    logic          scan_q, scan_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        fmt_d   = fmt_q;
        alg_d   = alg_q;
        p_src_d = p_src_q;
        p_fmt_d = p_fmt_q;
        p_alg_d = p_alg_q;
        tmo_d   = tmo_q;
`ifdef AUTO_SCAN_EN
        scan_d     = scan_q;
        scan_cnt_d = scan_cnt_q;
`endif
        if (state_q == MS_DISPLAY) begin
            tmo_d = '0;
            // enter is ignored here but still outranks (and so swallows) a coincident mode/up.
            if (mode_p && !enter_p) begin
                state_d = MS_SEL_SRC;
                p_src_d = src_q;
                p_fmt_d = fmt_q;
                p_alg_d = alg_q;
`ifdef AUTO_SCAN_EN
                scan_cnt_d = '0;
`endif
            end
`ifdef AUTO_SCAN_EN
            else begin
                if (up_p && !enter_p) begin
                    scan_d = ~scan_q;
                end
                if (scan_q) begin
                    if (scan_cnt_q == SW'(SCAN_PERIOD - 1)) begin
                        scan_cnt_d = '0;
                        src_d      = src_q + 2'd1;
                    end else begin
                        scan_cnt_d = scan_cnt_q + SW'(1);
                    end
                end
            end
`endif
        end else begin
            if (enter_p) begin
                src_d   = p_src_q;
                fmt_d   = p_fmt_q;
                alg_d   = p_alg_q;
                state_d = MS_DISPLAY;
`ifdef AUTO_SCAN_EN
                scan_d = 1'b0;
`endif
            end else if (mode_p) begin
                tmo_d = '0;
                case (state_q)
                    MS_SEL_SRC: state_d = MS_SEL_FMT;
                    MS_SEL_FMT: state_d = MS_SEL_ALG;
                    default:    state_d = MS_SEL_SRC;
                endcase
            end else if (up_p) begin
                tmo_d = '0;
                case (state_q)
                    MS_SEL_SRC: p_src_d = p_src_q + 2'd1;
                    MS_SEL_FMT: p_fmt_d = p_fmt_q + 2'd1;
                    default:    p_alg_d = ~p_alg_q;
                endcase
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = MS_DISPLAY;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        // Status outputs are registered off next-state so they switch on the same edge as the FSM.
        active_d = (state_d != MS_DISPLAY);
        disp_d   = menu_word(state_d, p_src_d, p_fmt_d, p_alg_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= MS_DISPLAY;
            src_q    <= SRC_XADC;
            fmt_q    <= FMT_RESET;
            alg_q    <= 1'b0;
            p_src_q  <= 2'b00;
            p_fmt_q  <= 2'b00;
            p_alg_q  <= 1'b0;
            tmo_q    <= '0;
            active_q <= 1'b0;
            disp_q   <= 16'h0000;
`ifdef AUTO_SCAN_EN
            scan_q     <= 1'b0;
            scan_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            fmt_q    <= fmt_d;
            alg_q    <= alg_d;
            p_src_q  <= p_src_d;
            p_fmt_q  <= p_fmt_d;
            p_alg_q  <= p_alg_d;
            tmo_q    <= tmo_d;
            active_q <= active_d;
            disp_q   <= disp_d;
`ifdef AUTO_SCAN_EN
            scan_q     <= scan_d;
            scan_cnt_q <= scan_cnt_d;
`endif
        end
    end

    assign adc_select       = src_q;
    assign bin_bcd_select   = fmt_q;
    assign algorithm_select = alg_q;
    assign menu_active      = active_q;
    assign menu_display     = disp_q;

endmodule

// File: tb/tb_adc_menu_controller.sv
// Directed plus random button sequences checked against a field/pending/committed menu model.
// Small debounce/timeout/scan parameters keep the run short.
module tb_adc_menu_controller;

    localparam int unsigned N  = 4;
    localparam int unsigned T  = 50;
    localparam int unsigned SP = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_enter = 1'b0;
    logic [1:0]  adc_select;
    logic [1:0]  bin_bcd_select;
    logic        algorithm_select;
    logic        menu_active;
    logic [15:0] menu_display;

    int total = 0;
    int bad   = 0;

    // Model: field 0 = display, 1..3 = SRC/FMT/ALG; pending and committed values.
    int m_st;
    int p_v[3];
    int c_v[3];

    always #5 clk = ~clk;

    adc_menu_controller #(
        .DEBOUNCE_CYCLES(N),
        .TIMEOUT_CYCLES(T),
        .SCAN_PERIOD(SP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .btn_enter(btn_enter),
        .adc_select(adc_select),
        .bin_bcd_select(bin_bcd_select),
        .algorithm_select(algorithm_select),
        .menu_active(menu_active),
        .menu_display(menu_display)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_disp();
        int v;
        if (m_st == 0) return 16'h0000;
        v = p_v[m_st - 1];
        return {4'(m_st), 8'h00, 4'(v)};
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".src"}, 32'(adc_select), 32'(c_v[0]));
        check({tag, ".fmt"}, 32'(bin_bcd_select), 32'(c_v[1]));
        check({tag, ".alg"}, 32'(algorithm_select), 32'(c_v[2]));
        check({tag, ".act"}, 32'(menu_active), 32'(m_st != 0));
        check({tag, ".disp"}, 32'(menu_display), 32'(exp_disp()));
    endtask

    function automatic void model_reset();
        m_st = 0;
        c_v[0] = 1; c_v[1] = 1; c_v[2] = 0;
        p_v[0] = 0; p_v[1] = 0; p_v[2] = 0;
    endfunction

    // One debounced press of each asserted button, all landing in the same cycle.
    function automatic void model_press(input bit m, input bit u, input bit e);
        if (e) begin
            if (m_st != 0) begin
                c_v = p_v;
                m_st = 0;
            end
        end else if (m) begin
            if (m_st == 0) begin
                p_v = c_v;
                m_st = 1;
            end else begin
                m_st = (m_st == 3) ? 1 : m_st + 1;
            end
        end else if (u && m_st != 0) begin
            if (m_st == 3) p_v[2] = 1 - p_v[2];
            else p_v[m_st - 1] = (p_v[m_st - 1] + 1) % 4;
        end
    endfunction

    task automatic press(input bit m, input bit u, input bit e);
        @(posedge clk); #1;
        btn_mode = m; btn_up = u; btn_enter = e;
        repeat (N + 6) @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_up = 1'b0; btn_enter = 1'b0;
        repeat (N + 6) @(posedge clk);
        #1;
        model_press(m, u, e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_init");
        reset = 1'b1;

        // 2: bouncing mode button, then a clean hold -> exactly one pulse
        for (int i = 0; i < 5; i++) begin
            btn_mode = ~btn_mode;
            idle(2);
        end
        check("bounce.act", 32'(menu_active), 32'd0);
        btn_mode = 1'b1;
        idle(10);
        btn_mode = 1'b0;
        idle(N + 6);
        model_press(1'b1, 1'b0, 1'b0);
        check("bounce.disp", 32'(menu_display), 32'h1001);
        check_all("bounce");
        press(1'b0, 1'b0, 1'b1);
        check_all("bounce_exit");

        // 3: mode, up, up, enter with commit timing one cycle after the pulse
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check_all("t3_pend");
        @(posedge clk); #1;
        btn_enter = 1'b1;
        repeat (N + 3) @(posedge clk);
        #1;
        check("t3.before", 32'(adc_select), 32'd1);
        check("t3.act_before", 32'(menu_active), 32'd1);
        @(posedge clk); #1;
        check("t3.after", 32'(adc_select), 32'd3);
        check("t3.act_after", 32'(menu_active), 32'd0);
        idle(2);
        btn_enter = 1'b0;
        idle(N + 6);
        model_press(1'b0, 1'b0, 1'b1);
        check_all("t3_done");

        // 4: source wrap, format and algorithm edits, field wrap back to SRC
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("t4.disp", 32'(menu_display), 32'h1000);
        press(1'b0, 1'b0, 1'b1);
        check("t4.src", 32'(adc_select), 32'd0);
        check("t4.fmt", 32'(bin_bcd_select), 32'd2);
        check("t4.alg", 32'(algorithm_select), 32'd1);

        // 5: inactivity timeout abandons edits
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        idle(25);
        check_all("t5_still_menu");
        idle(30);
        m_st = 0;
        check_all("t5_timeout");
        check("t5.src", 32'(adc_select), 32'd1);

        // 6: enter and up together -> commit without increment
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        check("t6.src", 32'(adc_select), 32'd2);
        check_all("t6_commit");

        // reset mid-menu discards edits
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        check("t6.reentry", 32'(menu_display), 32'h1001);
        press(1'b0, 1'b0, 1'b1);

`ifdef AUTO_SCAN_EN
        do_reset();
        press(1'b0, 1'b1, 1'b0);
        idle(5);
        check("scan.before", 32'(adc_select), 32'd1);
        idle(5);
        check("scan.after", 32'(adc_select), 32'd2);
        press(1'b0, 1'b1, 1'b0);
`endif

        // Random button sequences against the model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(0, 2);
`ifdef AUTO_SCAN_EN
            if (k == 1 && m_st == 0) k = 0;
`endif
            press(k == 0, k == 1, k == 2);
            check_all($sformatf("rnd%0d", it));
            if ($urandom_range(0, 4) == 0) begin
                idle(60);
                m_st = 0;
                check_all($sformatf("rnd_tmo%0d", it));
            end else begin
                idle($urandom_range(0, 15));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
